bram_true2port_be: RTL

True dual-port block RAM with per-byte write enables, configurable read-during-write behaviour, cross-port collision reporting and a hardware memory-clear sequence after reset. It is the parametrised successor of the plain true-2-port BRAM used for table and state storage in the GorillaPP templates. It keeps the same registered-input, registered-output pipeline and adds read-valid qualification so that consumers no longer track latency by hand.

---
 rtl/bram_true2port_be_pkg.sv | 28 ++
 rtl/bram_true2port_be_port_stage.sv | 93 +++++++++
 rtl/bram_true2port_be.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/bram_true2port_be_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bram_pkg
// Description : Shared types and helpers for the true dual-port byte-enable
//               BRAM (read-during-write mode, clear FSM states, lane count).
// Revision    : 1.0 - initial release
// ============================================================================
package bram_pkg;

   // Same-port read-during-write result selection
   typedef enum logic {
      READ_FIRST  = 1'b0,
      WRITE_FIRST = 1'b1
   } rdw_mode_e;

   // Post-reset memory clear sequencer
   typedef enum logic {
      INIT = 1'b0,
      RUN  = 1'b1
   } bram_init_state_e;

   // Number of byte-enable lanes; the top lane absorbs any leftover bits
   function automatic int nbytes(input int dwidth, input int byte_w);
      return (dwidth + byte_w - 1) / byte_w;
   endfunction

endpackage
`default_nettype wire

// File: rtl/bram_true2port_be_port_stage.sv
`default_nettype none
// ============================================================================
// Module      : bram_port_stage
// Description : One BRAM port: registered request, byte-lane merge of the
//               write data onto a base word, and the read data / read-valid
//               output register.
// Revision    : 1.0 - initial release
// ============================================================================
module bram_port_stage
   import bram_pkg::*;
#(
   parameter int        AWIDTH   = 12,
   parameter int        DWIDTH   = 253,
   parameter int        BYTE_W   = 8,
   parameter rdw_mode_e RDW_MODE = READ_FIRST,
   localparam int       NBYTES   = nbytes(DWIDTH, BYTE_W)
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_en,      // requests are dropped while low
   input  logic [AWIDTH-1:0] i_addr,
   input  logic [DWIDTH-1:0] i_data,
   input  logic [NBYTES-1:0] i_be,
   input  logic              i_wren,
   input  logic              i_rden,
   input  logic [DWIDTH-1:0] i_base,    // word the enabled lanes are merged onto
   input  logic [DWIDTH-1:0] i_old,     // array contents at the registered address
   input  logic [DWIDTH-1:0] i_post,    // word that ends up stored at that address
   output logic [AWIDTH-1:0] o_addr,
   output logic              o_wren,
   output logic              o_we,
   output logic [DWIDTH-1:0] o_merged,
   output logic [DWIDTH-1:0] o_q,
   output logic              o_q_valid
);

   logic [AWIDTH-1:0] r_addr;
   logic [DWIDTH-1:0] r_data;
   logic [NBYTES-1:0] r_be;
   logic              r_wren;
   logic              r_rden;
   logic [DWIDTH-1:0] w_mask;
   logic [DWIDTH-1:0] r_q;
   logic              r_q_valid;

   // Stage 1: capture the request, qualifying the enables with ready
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_addr <= '0;
         r_data <= '0;
         r_be   <= '0;
         r_wren <= 1'b0;
         r_rden <= 1'b0;
      end else begin
         r_addr <= i_addr;
         r_data <= i_data;
         r_be   <= i_be;
         r_wren <= i_wren & i_en;
         r_rden <= i_rden & i_en;
      end
   end

   // Expand lane enables to a per-bit mask (top lane may be narrower)
   always_comb begin
      w_mask = '0;
      for (int i = 0; i < DWIDTH; i++) begin
         w_mask[i] = r_be[i / BYTE_W];
      end
   end

   assign o_merged = (i_base & ~w_mask) | (r_data & w_mask);
   assign o_we     = r_wren & (|r_be);
   assign o_addr   = r_addr;
   assign o_wren   = r_wren;

   // Stage 2: register read data; q holds its value between reads
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_q       <= '0;
         r_q_valid <= 1'b0;
      end else begin
         r_q_valid <= r_rden;
         if (r_rden) begin
            r_q <= (RDW_MODE == WRITE_FIRST && r_wren) ? i_post : i_old;
         end
      end
   end

   assign o_q       = r_q;
   assign o_q_valid = r_q_valid;

endmodule
`default_nettype wire

// File: rtl/bram_true2port_be.sv
`default_nettype none
// ============================================================================
// Module      : bram_true2port_be
// Description : True dual-port block RAM with per-lane write enables,
//               selectable same-port read-during-write result, collision
//               pulse and a zero-fill sweep after every reset.
//               Define BRAM_TRUE2PORT_OUTREG_EN for an extra output register
//               stage (q, q_valid and collision all delayed one cycle).
// Revision    : 1.0 - initial release
// ============================================================================
module bram_true2port_be
   import bram_pkg::*;
#(
   parameter int        AWIDTH   = 12,
   parameter int        DWIDTH   = 253,
   parameter int        DEPTH    = 2048,
   parameter int        BYTE_W   = 8,
   parameter rdw_mode_e RDW_MODE = READ_FIRST,
   localparam int       NBYTES   = nbytes(DWIDTH, BYTE_W)
) (
   input  logic              clock,
   input  logic              reset_n,
   output logic              ready,
   input  logic [AWIDTH-1:0] address_a,
   input  logic [AWIDTH-1:0] address_b,
   input  logic [DWIDTH-1:0] data_a,
   input  logic [DWIDTH-1:0] data_b,
   input  logic [NBYTES-1:0] byteena_a,
   input  logic [NBYTES-1:0] byteena_b,
   input  logic              wren_a,
   input  logic              wren_b,
   input  logic              rden_a,
   input  logic              rden_b,
   output logic [DWIDTH-1:0] q_a,
   output logic [DWIDTH-1:0] q_b,
   output logic              q_valid_a,
   output logic              q_valid_b,
   output logic              collision
);

   localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   bram_init_state_e  r_state;
   bram_init_state_e  w_state_nxt;
   logic [MEM_AW-1:0] r_cnt;
   logic [MEM_AW-1:0] w_cnt_nxt;
   logic              w_clr_we;
   logic              r_ready;
   logic              r_collision;
   logic [DWIDTH-1:0] r_mem [0:DEPTH-1];

   logic [AWIDTH-1:0] w_addr_a, w_addr_b;
   logic              w_wren_a, w_wren_b;
   logic              w_we_a, w_we_b;
   logic [DWIDTH-1:0] w_merged_a, w_merged_b;
   logic [DWIDTH-1:0] w_old_a, w_old_b;
   logic [DWIDTH-1:0] w_base_a, w_post_b;
   logic              w_coll_now;
   logic [DWIDTH-1:0] w_q_a, w_q_b;
   logic              w_q_valid_a, w_q_valid_b;

   bram_port_stage #(
      .AWIDTH   (AWIDTH),
      .DWIDTH   (DWIDTH),
      .BYTE_W   (BYTE_W),
      .RDW_MODE (RDW_MODE)
   ) u_port_a (
      .i_clk     (clock),
      .i_rst_n   (reset_n),
      .i_en      (r_ready),
      .i_addr    (address_a),
      .i_data    (data_a),
      .i_be      (byteena_a),
      .i_wren    (wren_a),
      .i_rden    (rden_a),
      .i_base    (w_base_a),
      .i_old     (w_old_a),
      .i_post    (w_merged_a),
      .o_addr    (w_addr_a),
      .o_wren    (w_wren_a),
      .o_we      (w_we_a),
      .o_merged  (w_merged_a),
      .o_q       (w_q_a),
      .o_q_valid (w_q_valid_a)
   );

   bram_port_stage #(
      .AWIDTH   (AWIDTH),
      .DWIDTH   (DWIDTH),
      .BYTE_W   (BYTE_W),
      .RDW_MODE (RDW_MODE)
   ) u_port_b (
      .i_clk     (clock),
      .i_rst_n   (reset_n),
      .i_en      (r_ready),
      .i_addr    (address_b),
      .i_data    (data_b),
      .i_be      (byteena_b),
      .i_wren    (wren_b),
      .i_rden    (rden_b),
      .i_base    (w_old_b),
      .i_old     (w_old_b),
      .i_post    (w_post_b),
      .o_addr    (w_addr_b),
      .o_wren    (w_wren_b),
      .o_we      (w_we_b),
      .o_merged  (w_merged_b),
      .o_q       (w_q_b),
      .o_q_valid (w_q_valid_b)
   );

   assign w_old_a = r_mem[w_addr_a[MEM_AW-1:0]];
   assign w_old_b = r_mem[w_addr_b[MEM_AW-1:0]];

   // On a shared write address A merges on top of B's result, so A's lanes
   // win and B-only lanes survive; both ports then see the same final word.
   assign w_coll_now = w_wren_a & w_wren_b & (w_addr_a == w_addr_b);
   assign w_base_a   = w_coll_now ? w_merged_b : w_old_a;
   assign w_post_b   = w_coll_now ? w_merged_a : w_merged_b;

   // Clear sequencer state register
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_state <= INIT;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Clear sequencer: zero one word per cycle, then hand over to RUN
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clr_we    = 1'b0;
      case (r_state)
         INIT: begin
            w_clr_we = 1'b1;
            if (r_cnt == MEM_AW'(DEPTH - 1)) begin
               w_state_nxt = RUN;
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         RUN:     w_state_nxt = RUN;
         default: w_state_nxt = INIT;
      endcase
   end

   // Array write port: clear sweep, or B then A so A's word lands last
   always_ff @(posedge clock) begin
      if (reset_n) begin
         if (w_clr_we) begin
            r_mem[r_cnt] <= '0;
         end else begin
            if (w_we_b) r_mem[w_addr_b[MEM_AW-1:0]] <= w_merged_b;
            if (w_we_a) r_mem[w_addr_a[MEM_AW-1:0]] <= w_merged_a;
         end
      end
   end

   // ready lags RUN by one cycle; collision aligns with the stage-2 q_valid
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_ready     <= 1'b0;
         r_collision <= 1'b0;
      end else begin
         r_ready     <= (r_state == RUN);
         r_collision <= w_coll_now;
      end
   end

   assign ready = r_ready;

`ifdef BRAM_TRUE2PORT_OUTREG_EN
   logic [DWIDTH-1:0] r_q_a_d, r_q_b_d;
   logic              r_qv_a_d, r_qv_b_d, r_coll_d;

   // Extra output register stage, delays data, valids and collision together
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         r_q_a_d  <= '0;
         r_q_b_d  <= '0;
         r_qv_a_d <= 1'b0;
         r_qv_b_d <= 1'b0;
         r_coll_d <= 1'b0;
      end else begin
         r_q_a_d  <= w_q_a;
         r_q_b_d  <= w_q_b;
         r_qv_a_d <= w_q_valid_a;
         r_qv_b_d <= w_q_valid_b;
         r_coll_d <= r_collision;
      end
   end

   assign q_a       = r_q_a_d;
   assign q_b       = r_q_b_d;
   assign q_valid_a = r_qv_a_d;
   assign q_valid_b = r_qv_b_d;
   assign collision = r_coll_d;
`else
   assign q_a       = w_q_a;
   assign q_b       = w_q_b;
   assign q_valid_a = w_q_valid_a;
   assign q_valid_b = w_q_valid_b;
   assign collision = r_collision;
`endif

endmodule
`default_nettype wire
